elevator_sched_ctrl: RTL and testbench



---
 rtl/elevator_pkg.sv | 21 ++
 rtl/elevator_req_eval.sv | 32 +++
 rtl/elevator_sched_ctrl.sv | 99 +++++++++
 tb/tb_elevator_sched_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared constants, state type and call-bit helpers for the elevator scheduler
package elevator_pkg;
  localparam int NUM_FLOORS = 4;
  localparam int CALL_F0_UP = 0;
  localparam int CALL_F1_UP = 1;
  localparam int CALL_F1_DN = 2;
  localparam int CALL_F2_UP = 3;
  localparam int CALL_F2_DN = 4;
  localparam int CALL_F3_DN = 5;
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;
  function automatic logic [5:0] call_mask(input logic [1:0] f, input logic up);
    return 6'(1) << (f == 2'd0 ? CALL_F0_UP : f == 2'd3 ? CALL_F3_DN :
                     f == 2'd1 ? (up ? CALL_F1_UP : CALL_F1_DN) : (up ? CALL_F2_UP : CALL_F2_DN));
  endfunction
  function automatic logic [NUM_FLOORS-1:0] up_calls(input logic [5:0] c);
    return {1'b0, c[CALL_F2_UP], c[CALL_F1_UP], c[CALL_F0_UP]};
  endfunction
  function automatic logic [NUM_FLOORS-1:0] dn_calls(input logic [5:0] c);
    return {c[CALL_F3_DN], c[CALL_F2_DN], c[CALL_F1_DN], 1'b0};
  endfunction
endpackage

// File: rtl/elevator_req_eval.sv
// elevator_req_eval: request direction, stop and door-entry clear decisions for one floor
module elevator_req_eval import elevator_pkg::*; (
  input  logic [NUM_FLOORS-1:0] dest_i,
  input  logic [5:0]            call_i,
  input  logic [1:0]            flr_i,
  input  logic                  dir_up_i,
  output logic                  above_o,
  output logic                  below_o,
  output logic                  here_o,
  output logic                  stop_up_o,
  output logic                  stop_dn_o,
  output logic                  flip_o,
  output logic [NUM_FLOORS-1:0] clr_dest_o,
  output logic [5:0]            clr_call_o
);
  logic [NUM_FLOORS-1:0] up_f, dn_f, req, hi_m, lo_m;
  logic at_call;
  assign up_f = up_calls(call_i);
  assign dn_f = dn_calls(call_i);
  assign req = dest_i | up_f | dn_f;
  assign hi_m = 4'b1110 << flr_i;
  assign lo_m = ~(4'b1111 << flr_i);
  assign above_o = |(req & hi_m);
  assign below_o = |(req & lo_m);
  assign here_o = req[flr_i];
  assign at_call = up_f[flr_i] | dn_f[flr_i];
  assign stop_up_o = dest_i[flr_i] | up_f[flr_i] | (flr_i == 2'd3) | (~above_o & at_call);
  assign stop_dn_o = dest_i[flr_i] | dn_f[flr_i] | (flr_i == 2'd0) | (~below_o & at_call);
  assign flip_o = dir_up_i ? ~above_o : ~below_o;
  assign clr_dest_o = 4'(1) << flr_i;
  assign clr_call_o = call_mask(flr_i, dir_up_i) | (flip_o ? call_mask(flr_i, ~dir_up_i) : 6'd0);
endmodule

// File: rtl/elevator_sched_ctrl.sv
// elevator_sched_ctrl: request latching, direction scheduling and motion/door sequencing
module elevator_sched_ctrl import elevator_pkg::*; #(
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 6,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dest_btn,
  input  logic [5:0] call_btn,
  output logic [3:0] dest_lamp,
  output logic [5:0] call_lamp,
  output logic [1:0] cur_floor,
  output logic       dir_up,
  output logic       moving,
  output logic       door_open
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0] floor_q, nf;
  logic dir_q, dir_d;
  logic [NUM_FLOORS-1:0] dest_q, dest_d, blk_dest, clr_dest, ev_clr_dest;
  logic [5:0] call_q, call_d, blk_call, clr_call, ev_clr_call;
  logic above, below, here, stop_up, stop_dn, flip;
  logic tc_move, tc_door, restart, enter_door;
  assign tc_move = timer_q == CNT_W'(MOVE_CYCLES - 1);
  assign tc_door = timer_q == CNT_W'(DOOR_CYCLES - 1);
  assign nf = state_q == MOVE_UP && tc_move ? floor_q + 2'd1 :
              state_q == MOVE_DOWN && tc_move ? floor_q - 2'd1 : floor_q;
  assign blk_dest = state_q == DOOR_OPEN ? 4'(1) << floor_q : 4'd0;
  assign blk_call = state_q == DOOR_OPEN ? call_mask(floor_q, dir_q) : 6'd0;
  assign restart = |(dest_btn & blk_dest) | |(call_btn & blk_call);
  elevator_req_eval u_eval (
    .dest_i(dest_q), .call_i(call_q), .flr_i(nf), .dir_up_i(dir_q),
    .above_o(above), .below_o(below), .here_o(here),
    .stop_up_o(stop_up), .stop_dn_o(stop_dn), .flip_o(flip),
    .clr_dest_o(ev_clr_dest), .clr_call_o(ev_clr_call)
  );
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d = dir_q;
    enter_door = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (here) begin
          state_d = DOOR_OPEN;
          enter_door = 1'b1;
        end else if (dir_q ? above : above & ~below) begin
          state_d = MOVE_UP;
          dir_d = 1'b1;
        end else if (below) begin
          state_d = MOVE_DOWN;
          dir_d = 1'b0;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        timer_d = tc_move ? '0 : timer_q + CNT_W'(1);
        if (tc_move && (state_q == MOVE_UP ? stop_up : stop_dn)) begin
          state_d = DOOR_OPEN;
          enter_door = 1'b1;
        end
      end
      DOOR_OPEN: begin
        timer_d = restart || tc_door ? '0 : timer_q + CNT_W'(1);
        state_d = !restart && tc_door ? IDLE : DOOR_OPEN;
      end
    endcase
    dir_d = enter_door && flip ? ~dir_q : dir_d;
  end
  assign clr_dest = enter_door ? ev_clr_dest : 4'd0;
  assign clr_call = enter_door ? ev_clr_call : 6'd0;
  assign dest_d = (dest_q | (dest_btn & ~blk_dest)) & ~clr_dest;
  assign call_d = (call_q | (call_btn & ~blk_call)) & ~clr_call;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      floor_q <= 2'd0;
      dir_q <= 1'b1;
      dest_q <= '0;
      call_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      floor_q <= nf;
      dir_q <= dir_d;
      dest_q <= dest_d;
      call_q <= call_d;
    end
  end
  assign dest_lamp = dest_q;
  assign call_lamp = call_q;
  assign cur_floor = floor_q;
  assign dir_up = dir_q;
  assign moving = state_q == MOVE_UP || state_q == MOVE_DOWN;
  assign door_open = state_q == DOOR_OPEN;
endmodule

// File: tb/tb_elevator_sched_ctrl.sv
// tb_elevator_sched_ctrl: directed vector table plus randomized run against a behavioural model
module tb_elevator_sched_ctrl;
  localparam int MOVE = 4;
  localparam int DOOR = 6;
  localparam int M_IDLE = 0, M_MOVE = 1, M_DOOR = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] dest_btn = '0;
  logic [5:0] call_btn = '0;
  logic [3:0] dest_lamp;
  logic [5:0] call_lamp;
  logic [1:0] cur_floor;
  logic dir_up, moving, door_open;
  int checks = 0;
  int errors = 0;
  elevator_sched_ctrl #(.MOVE_CYCLES(MOVE), .DOOR_CYCLES(DOOR), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .dest_btn(dest_btn), .call_btn(call_btn),
    .dest_lamp(dest_lamp), .call_lamp(call_lamp), .cur_floor(cur_floor),
    .dir_up(dir_up), .moving(moving), .door_open(door_open)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit r; logic [3:0] d; logic [5:0] c; int n;
    int fl; bit dir; bit mv; bit dr; logic [3:0] dl; logic [5:0] cl;
  } vec_t;
  vec_t tv[$];
  int m_mode, m_floor, m_cnt, m_left;
  bit m_up;
  bit pd[4], pu[4], pn[4];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic void add(bit r, logic [3:0] d, logic [5:0] c, int n, int fl, bit dir,
                              bit mv, bit dr, logic [3:0] dl, logic [5:0] cl);
    tv.push_back('{r, d, c, n, fl, dir, mv, dr, dl, cl});
  endfunction
  function automatic bit any_at(int g);
    return pd[g] | pu[g] | pn[g];
  endfunction
  function automatic bit req_above(int f);
    for (int g = f + 1; g < 4; g++) if (any_at(g)) return 1'b1;
    return 1'b0;
  endfunction
  function automatic bit req_below(int f);
    for (int g = 0; g < f; g++) if (any_at(g)) return 1'b1;
    return 1'b0;
  endfunction
  task automatic model_step(input bit r, input logic [3:0] db, input logic [5:0] cb);
    bit up_pr[4], dn_pr[4], bd[4], bu[4], bn[4], cd[4], cu[4], cn[4];
    bit restart, open, stop;
    int f;
    restart = 1'b0;
    open = 1'b0;
    if (r) begin
      m_mode = M_IDLE; m_floor = 0; m_up = 1'b1; m_cnt = 0; m_left = 0;
      for (int g = 0; g < 4; g++) begin pd[g] = 0; pu[g] = 0; pn[g] = 0; end
      return;
    end
    up_pr[0] = cb[0]; up_pr[1] = cb[1]; up_pr[2] = cb[3];
    dn_pr[1] = cb[2]; dn_pr[2] = cb[4]; dn_pr[3] = cb[5];
    if (m_mode == M_DOOR) begin
      bd[m_floor] = 1'b1;
      if (m_floor == 0 || (m_up && m_floor != 3)) bu[m_floor] = 1'b1;
      else bn[m_floor] = 1'b1;
      restart = db[m_floor] | (bu[m_floor] & up_pr[m_floor]) | (bn[m_floor] & dn_pr[m_floor]);
    end
    if (m_mode == M_IDLE) begin
      if (any_at(m_floor)) open = 1'b1;
      else if (m_up) begin
        if (req_above(m_floor)) begin m_mode = M_MOVE; m_cnt = 0; end
        else if (req_below(m_floor)) begin m_mode = M_MOVE; m_cnt = 0; m_up = 1'b0; end
      end else begin
        if (req_below(m_floor)) begin m_mode = M_MOVE; m_cnt = 0; end
        else if (req_above(m_floor)) begin m_mode = M_MOVE; m_cnt = 0; m_up = 1'b1; end
      end
    end else if (m_mode == M_MOVE) begin
      m_cnt++;
      if (m_cnt == MOVE) begin
        m_cnt = 0;
        m_floor = m_up ? m_floor + 1 : m_floor - 1;
        f = m_floor;
        stop = m_up ? (pd[f] || pu[f] || f == 3 || (!req_above(f) && (pu[f] || pn[f])))
                    : (pd[f] || pn[f] || f == 0 || (!req_below(f) && (pu[f] || pn[f])));
        if (stop) open = 1'b1;
      end
    end else begin
      if (restart) m_left = DOOR;
      else begin
        m_left--;
        if (m_left == 0) m_mode = M_IDLE;
      end
    end
    if (open) begin
      f = m_floor;
      cd[f] = 1'b1;
      if (m_up) cu[f] = 1'b1; else cn[f] = 1'b1;
      if (m_up ? !req_above(f) : !req_below(f)) begin
        cu[f] = 1'b1; cn[f] = 1'b1; m_up = !m_up;
      end
      if (f == 0) cu[0] = 1'b1;
      if (f == 3) cn[3] = 1'b1;
      m_mode = M_DOOR;
      m_left = DOOR;
    end
    for (int g = 0; g < 4; g++) begin
      pd[g] = (pd[g] | (db[g] & !bd[g])) & !cd[g];
      pu[g] = (pu[g] | (up_pr[g] & !bu[g])) & !cu[g];
      pn[g] = (pn[g] | (dn_pr[g] & !bn[g])) & !cn[g];
    end
  endtask
  initial begin
    add(1, 4'b0000, 6'b000000, 2, 0, 1, 0, 0, 4'b0000, 6'b000000);
    add(0, 4'b0100, 6'b000000, 1, 0, 1, 0, 0, 4'b0100, 6'b000000);
    add(0, 4'b0000, 6'b000000, 1, 0, 1, 1, 0, 4'b0100, 6'b000000);
    add(0, 4'b0000, 6'b000000, 4, 1, 1, 1, 0, 4'b0100, 6'b000000);
    add(0, 4'b0000, 6'b000000, 3, 1, 1, 1, 0, 4'b0100, 6'b000000);
    add(0, 4'b0000, 6'b000000, 1, 2, 0, 0, 1, 4'b0000, 6'b000000);
    add(0, 4'b0000, 6'b000000, 5, 2, 0, 0, 1, 4'b0000, 6'b000000);
    add(0, 4'b0000, 6'b000000, 1, 2, 0, 0, 0, 4'b0000, 6'b000000);
    add(0, 4'b0010, 6'b000000, 1, 2, 0, 0, 0, 4'b0010, 6'b000000);
    add(0, 4'b0000, 6'b000000, 1, 2, 0, 1, 0, 4'b0010, 6'b000000);
    add(0, 4'b0000, 6'b000000, 4, 1, 1, 0, 1, 4'b0000, 6'b000000);
    add(0, 4'b0000, 6'b000000, 6, 1, 1, 0, 0, 4'b0000, 6'b000000);
    add(0, 4'b0000, 6'b000110, 1, 1, 1, 0, 0, 4'b0000, 6'b000110);
    add(0, 4'b0000, 6'b000000, 1, 1, 0, 0, 1, 4'b0000, 6'b000000);
    add(1, 4'b0000, 6'b000000, 2, 0, 1, 0, 0, 4'b0000, 6'b000000);
    add(0, 4'b1000, 6'b000000, 1, 0, 1, 0, 0, 4'b1000, 6'b000000);
    add(0, 4'b0000, 6'b010000, 1, 0, 1, 1, 0, 4'b1000, 6'b010000);
    add(0, 4'b0000, 6'b000000, 8, 2, 1, 1, 0, 4'b1000, 6'b010000);
    add(0, 4'b0000, 6'b000000, 4, 3, 0, 0, 1, 4'b0000, 6'b010000);
    add(0, 4'b0000, 6'b000000, 7, 3, 0, 1, 0, 4'b0000, 6'b010000);
    add(0, 4'b0000, 6'b000000, 4, 2, 1, 0, 1, 4'b0000, 6'b000000);
    add(0, 4'b0100, 6'b000000, 3, 2, 1, 0, 1, 4'b0000, 6'b000000);
    add(0, 4'b0000, 6'b000000, 3, 2, 1, 0, 1, 4'b0000, 6'b000000);
    add(0, 4'b0000, 6'b000000, 1, 2, 1, 0, 0, 4'b0000, 6'b000000);
    add(0, 4'b0010, 6'b000000, 1, 2, 1, 0, 0, 4'b0010, 6'b000000);
    add(0, 4'b0000, 6'b000000, 1, 2, 0, 1, 0, 4'b0010, 6'b000000);
    add(0, 4'b0000, 6'b000000, 4, 1, 1, 0, 1, 4'b0000, 6'b000000);
    add(0, 4'b0000, 6'b000000, 6, 1, 1, 0, 0, 4'b0000, 6'b000000);
    add(0, 4'b1001, 6'b000000, 1, 1, 1, 0, 0, 4'b1001, 6'b000000);
    add(0, 4'b0000, 6'b000000, 1, 1, 1, 1, 0, 4'b1001, 6'b000000);
    add(0, 4'b0000, 6'b000000, 8, 3, 0, 0, 1, 4'b0001, 6'b000000);
    add(0, 4'b0000, 6'b000000, 7, 3, 0, 1, 0, 4'b0001, 6'b000000);
    add(0, 4'b0000, 6'b000000, 12, 0, 1, 0, 1, 4'b0000, 6'b000000);
    add(0, 4'b0000, 6'b000000, 6, 0, 1, 0, 0, 4'b0000, 6'b000000);
    add(0, 4'b0100, 6'b000000, 1, 0, 1, 0, 0, 4'b0100, 6'b000000);
    add(0, 4'b0000, 6'b000000, 6, 1, 1, 1, 0, 4'b0100, 6'b000000);
    add(1, 4'b0000, 6'b000000, 1, 0, 1, 0, 0, 4'b0000, 6'b000000);
    foreach (tv[i]) begin
      rst = tv[i].r;
      dest_btn = tv[i].d;
      call_btn = tv[i].c;
      tick();
      dest_btn = '0;
      call_btn = '0;
      repeat (tv[i].n - 1) tick();
      chk($sformatf("vec%0d floor", i), 32'(cur_floor), 32'(tv[i].fl));
      chk($sformatf("vec%0d dir_up", i), 32'(dir_up), 32'(tv[i].dir));
      chk($sformatf("vec%0d moving", i), 32'(moving), 32'(tv[i].mv));
      chk($sformatf("vec%0d door_open", i), 32'(door_open), 32'(tv[i].dr));
      chk($sformatf("vec%0d dest_lamp", i), 32'(dest_lamp), 32'(tv[i].dl));
      chk($sformatf("vec%0d call_lamp", i), 32'(call_lamp), 32'(tv[i].cl));
    end
    rst = 1'b1;
    tick();
    model_step(1'b1, 4'd0, 6'd0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = $urandom_range(0, 599) == 0;
      dest_btn = $urandom_range(0, 5) == 0 ? 4'($urandom_range(0, 15)) : 4'd0;
      call_btn = $urandom_range(0, 5) == 0 ? 6'($urandom_range(0, 63)) : 6'd0;
      tick();
      model_step(rst, dest_btn, call_btn);
      chk($sformatf("rand%0d floor", cyc), 32'(cur_floor), 32'(m_floor));
      chk($sformatf("rand%0d dir_up", cyc), 32'(dir_up), 32'(m_up));
      chk($sformatf("rand%0d moving", cyc), 32'(moving), 32'(m_mode == M_MOVE));
      chk($sformatf("rand%0d door_open", cyc), 32'(door_open), 32'(m_mode == M_DOOR));
      chk($sformatf("rand%0d dest_lamp", cyc), 32'(dest_lamp), 32'({pd[3], pd[2], pd[1], pd[0]}));
      chk($sformatf("rand%0d call_lamp", cyc), 32'(call_lamp),
          32'({pn[3], pn[2], pu[2], pn[1], pu[1], pu[0]}));
    end
    rst = 1'b0;
    dest_btn = '0;
    call_btn = '0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
